uart_rx_mmio: RTL

- UART receiver: the receive-side counterpart of the core's store-triggered UART transmitter.
- Deserialises 8N1 frames from the uart_rx pin into a small byte FIFO.
- Exposes data and status to the CPU through load-path memory-mapped reads at two fixed addresses.
- Sits beside the data-memory load path. Its r_data is zero when not addressed, so the top level ORs it with the memory read data.

---
 rtl/uart_rx_mmio.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_mmio.sv
// ---------------------------------------------------------------------------
// uart_rx_mmio
//   8N1 UART receiver with a small byte FIFO. The CPU reads it through two
//   load-path addresses. r_data is zero when this block is not addressed, so
//   the top level can OR it with the data-memory read data.
//
// Ports
//   clk       in   1   system clock
//   nrst      in   1   asynchronous active-low reset
//   uart_rx   in   1   serial input, idle high
//   address   in  32   load address from the execute stage
//   is_load   in   1   a load instruction is executing this cycle
//   r_data    out 32   combinational read data, zero-extended
//   rx_valid  out  1   registered FIFO non-empty flag
//
// Register map
//   RX_DATA_ADDR  {24'b0, head byte}; a load pops one byte (0 when empty)
//   RX_STAT_ADDR  {26'b0, count[5:2], frame_err[1], overrun[0]};
//                 a load clears frame_err and overrun
// ---------------------------------------------------------------------------
module uart_rx_mmio #(
   parameter int unsigned CLKS_PER_BIT = 1085,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter logic [31:0] RX_DATA_ADDR = 32'h0000_ff04,
   parameter logic [31:0] RX_STAT_ADDR = 32'h0000_ff08
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        uart_rx,
   input  logic [31:0] address,
   input  logic        is_load,
   output logic [31:0] r_data,
   output logic        rx_valid
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);

   localparam logic [CLK_W-1:0] HALF_LAST = CLK_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // synchroniser
   logic             r_rx_meta;
   logic             r_rx_s;

   // receive FSM
   logic [1:0]       r_state;
   logic [CLK_W-1:0] r_clk_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;

   // FIFO
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overrun;
   logic             r_frame_err;

   logic             w_stop_smp;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_ovr_set;
   logic             w_fe_set;
   logic             w_stat_rd;
   logic [CNT_W-1:0] w_count_nxt;
   logic [3:0]       w_count4;

   // ------------------------------------------------------------------
   // Two-flop input synchroniser, reset to the idle (high) line level
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= uart_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_state   <= S_START;
                  r_clk_cnt <= '0;
               end
            end
            S_START: begin
               if (r_clk_cnt == HALF_LAST) begin
                  r_clk_cnt <= '0;
                  if (!r_rx_s) begin
                     r_state   <= S_DATA;
                     r_bit_cnt <= '0;
                  end else begin
                     // line back high at mid-start: treat as a glitch
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CLK_W'(1);
               end
            end
            S_DATA: begin
               if (r_clk_cnt == BIT_LAST) begin
                  r_clk_cnt          <= '0;
                  r_shift[r_bit_cnt] <= r_rx_s;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CLK_W'(1);
               end
            end
            S_STOP: begin
               // return to IDLE on the sample edge; a held-low line
               // therefore re-enters START on the next cycle
               if (r_clk_cnt == BIT_LAST) begin
                  r_clk_cnt <= '0;
                  r_state   <= S_IDLE;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CLK_W'(1);
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_clk_cnt <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   assign w_stop_smp = (r_state == S_STOP) && (r_clk_cnt == BIT_LAST);
   assign w_full     = (r_count == FULL_CNT);
   assign w_empty    = (r_count == '0);
   assign w_pop      = is_load && (address == RX_DATA_ADDR) && !w_empty;
   assign w_stat_rd  = is_load && (address == RX_STAT_ADDR);

   // a same-cycle pop frees a slot, so a full FIFO still accepts the byte
   assign w_push    = w_stop_smp && r_rx_s && (!w_full || w_pop);
   assign w_ovr_set = w_stop_smp && r_rx_s && w_full && !w_pop;
   assign w_fe_set  = w_stop_smp && !r_rx_s;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         rx_valid    <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count  <= w_count_nxt;
         rx_valid <= (w_count_nxt != '0);

         // a set event beats the clear-on-status-read
         if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end else if (w_stat_rd) begin
            r_overrun <= 1'b0;
         end
         if (w_fe_set) begin
            r_frame_err <= 1'b1;
         end else if (w_stat_rd) begin
            r_frame_err <= 1'b0;
         end
      end
   end

   // storage has no reset; an entry is only visible once it has been written
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_shift;
      end
   end

   // ------------------------------------------------------------------
   // Combinational read decode
   // ------------------------------------------------------------------
   assign w_count4 = 4'(r_count);

   always_comb begin
      r_data = '0;
      if (is_load) begin
         if (address == RX_DATA_ADDR) begin
            if (!w_empty) begin
               r_data = {24'b0, r_mem[r_rd_ptr]};
            end
         end else if (address == RX_STAT_ADDR) begin
            r_data = {26'b0, w_count4, r_frame_err, r_overrun};
         end
      end
   end

endmodule
